data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory controller for a RISC-V style datapath.
// Holds 2^ADDR_W bytes as little-endian 32-bit words. A load or store request
// is captured in IDLE, waits WAIT_CYC cycles, executes in ACCESS and signals
// completion with a one-cycle done pulse in the following IDLE cycle.
//
// Handshake: the datapath raises MemRead or MemWrite and holds the request
// (with addr/Funct3/wr_data) until it sees done; it drops or changes the
// request on the following edge. busy tells the datapath to stall. A request
// is accepted only in IDLE while done is low, so a request still held in the
// done cycle is not taken twice.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (memory contents are kept)
//   MemRead   load request
//   MemWrite  store request
//   Funct3    access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr      byte address
//   wr_data   store data, right-aligned
//   rd_data   load result, sign/zero extended; 0 after an erroring access
//   busy      stall to datapath
//   done      one-cycle completion pulse
//   err       one-cycle error pulse, coincident with done
module data_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  // Last value of the wait counter before moving to ACCESS.
  localparam logic [2:0] WAIT_LAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t              state;
  logic [2:0]          wcnt;
  logic                cap_rd;
  logic                cap_wr;
  logic [2:0]          cap_f3;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  logic [31:0]         mem [DEPTH];

  logic                req;
  logic                accept;
  logic [31:0]         word;
  logic [31:0]         shifted;
  logic [15:0]         half;
  logic                bad_f3;
  logic                misalign;
  logic                xerr;
  logic [31:0]         load_v;
  logic [3:0]          be;
  logic [31:0]         wdata_rep;
  logic                wen;

  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req && !done;
  assign busy   = (state != IDLE) | (req & ~done);

  // Decode of the captured transaction; only meaningful in ACCESS.
  always_comb begin
    word      = mem[cap_addr[ADDR_W-1:2]];
    shifted   = word >> {cap_addr[1:0], 3'b000};
    half      = cap_addr[1] ? word[31:16] : word[15:0];
    bad_f3    = 1'b0;
    misalign  = 1'b0;
    load_v    = 32'd0;
    be        = 4'b0000;
    wdata_rep = 32'd0;

    if (cap_wr) begin
      bad_f3 = (cap_f3 > 3'b010);
    end else begin
      bad_f3 = !(cap_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    misalign = ((cap_f3[1:0] == 2'b01) && cap_addr[0]) ||
               ((cap_f3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
    // Simultaneous load and store is treated as an illegal request.
    xerr = (cap_rd && cap_wr) || bad_f3 || misalign;

    case (cap_f3)
      3'b000:  load_v = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_v = {{16{half[15]}}, half};
      3'b010:  load_v = word;
      3'b100:  load_v = {24'd0, shifted[7:0]};
      3'b101:  load_v = {16'd0, half};
      default: load_v = 32'd0;
    endcase

    // Replicate store data across lanes; byte enables pick the target lanes.
    case (cap_f3)
      3'b000: begin
        be        = 4'b0001 << cap_addr[1:0];
        wdata_rep = {4{cap_wdata[7:0]}};
      end
      3'b001: begin
        be        = cap_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cap_wdata[15:0]}};
      end
      3'b010: begin
        be        = 4'b1111;
        wdata_rep = cap_wdata[31:0];
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'd0;
      end
    endcase
  end

  // Reset sampled on the ACCESS edge suppresses the commit.
  assign wen = (state == ACCESS) && cap_wr && !xerr && !reset;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen && be[i]) begin
        mem[cap_addr[ADDR_W-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= 3'd0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_f3    <= 3'd0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_rd    <= MemRead;
            cap_wr    <= MemWrite;
            cap_f3    <= Funct3;
            cap_addr  <= addr;
            cap_wdata <= wr_data;
            wcnt      <= 3'd0;
            state     <= (WAIT_CYC > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (wcnt == WAIT_LAST) begin
            state <= ACCESS;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        ACCESS: begin
          state <= IDLE;
          done  <= 1'b1;
          err   <= xerr;
          if (xerr) begin
            rd_data <= '0;
          end else if (cap_rd) begin
            rd_data <= DATA_W'(load_v);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl. Two instances: WAIT_CYC=2 (main phase)
// and WAIT_CYC=0 (second phase). They share the request inputs; the unused
// instance is held in reset and the observed outputs are muxed by phase.
// The driver pushes the expected response when issuing a request; the monitor
// pops and compares on every done pulse, including latency from acceptance.
module tb_data_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset2, reset0;
  logic          MemRead, MemWrite;
  logic [2:0]    Funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd2, rd0;
  logic          busy2, busy0, done2, done0, err2, err0;
  logic          phase;

  logic [DW-1:0] rd_m;
  logic          busy_m, done_m, err_m;

  // clock / reset
  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(2)) dut (
    .clk(clk), .reset(reset2), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .addr(addr), .wr_data(wr_data),
    .rd_data(rd2), .busy(busy2), .done(done2), .err(err2)
  );

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(0)) dut0 (
    .clk(clk), .reset(reset0), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .addr(addr), .wr_data(wr_data),
    .rd_data(rd0), .busy(busy0), .done(done0), .err(err0)
  );

  assign rd_m   = phase ? rd0   : rd2;
  assign busy_m = phase ? busy0 : busy2;
  assign done_m = phase ? done0 : done2;
  assign err_m  = phase ? err0  : err2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done_m) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("err", {31'd0, err_m}, {31'd0, mon_e.err});
        if (mon_e.chk) check("rd_data", rd_m, mon_e.rd);
        check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end else if (err_m) begin
      vectors++;
      miscompares++;
      $display("FAIL err_without_done: got err=1 expected 0 (cycle %0d)", cyc);
    end
  end

  // driver: called at a negedge; returns at the negedge of the done cycle
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr,
                        input logic chk, input logic keep);
    exp_t e;
    bit   got;
    MemRead  = rd;
    MemWrite = wr;
    Funct3   = f3;
    addr     = a;
    wr_data  = d;
    // A request presented while done is high is taken one cycle later.
    e.acc = cyc + (done_m ? 1 : 0);
    e.lat = phase ? 2 : 4;
    e.rd  = erd;
    e.err = eerr;
    e.chk = chk;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done_m) begin
        got = 1'b1;
        check("busy_at_done", {31'd0, busy_m}, 32'd0);
      end else begin
        check("busy_pending", {31'd0, busy_m}, 32'd1);
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected one within 20 cycles");
    end
    if (!keep) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    phase = 1'b0; reset2 = 1'b1; reset0 = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd", rd_m, 32'd0);
    check("reset_done", {31'd0, done_m}, 32'd0);
    check("reset_busy", {31'd0, busy_m}, 32'd0);
    reset2 = 1'b0;
    @(negedge clk);

    // basic stores/loads                rd wr f3      addr    data          exp rd        err chk keep
    do_req(0, 1, 3'b010, 9'h020, 32'hCAFEF00D, 32'h0,        0, 0, 0);
    do_req(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1, 0);
    do_req(1, 0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFDE, 0, 1, 0);
    do_req(1, 0, 3'b100, 9'h013, 32'h0,        32'h000000DE, 0, 1, 0);
    do_req(1, 0, 3'b001, 9'h012, 32'h0,        32'hFFFFDEAD, 0, 1, 0);
    do_req(1, 0, 3'b101, 9'h010, 32'h0,        32'h0000BEEF, 0, 1, 0);
    // byte store preserves other lanes
    do_req(0, 1, 3'b000, 9'h011, 32'h00000055, 32'h0,        0, 0, 0);
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 0, 1, 0);
    do_req(1, 0, 3'b000, 9'h011, 32'h0,        32'h00000055, 0, 1, 0);
    // error cases: rd_data forced to 0, memory untouched
    do_req(1, 0, 3'b010, 9'h012, 32'h0,        32'h0,        1, 1, 0);
    do_req(0, 1, 3'b001, 9'h011, 32'h0000FFFF, 32'h0,        1, 1, 0);
    do_req(1, 1, 3'b010, 9'h010, 32'h0,        32'h0,        1, 1, 0);
    do_req(1, 0, 3'b011, 9'h010, 32'h0,        32'h0,        1, 1, 0);
    do_req(0, 1, 3'b100, 9'h010, 32'h0,        32'h0,        1, 1, 0);
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 0, 1, 0);
    // upper halfword store
    do_req(0, 1, 3'b001, 9'h012, 32'h0000A1B2, 32'h0,        0, 0, 0);
    do_req(1, 0, 3'b101, 9'h012, 32'h0,        32'h0000A1B2, 0, 1, 0);
    do_req(1, 0, 3'b001, 9'h012, 32'h0,        32'hFFFFA1B2, 0, 1, 0);
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hA1B255EF, 0, 1, 0);

    // store aborted by reset in the ACCESS cycle: no done, no commit
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'b010; addr = 9'h020; wr_data = 32'h12345678;
    repeat (3) @(negedge clk);
    reset2 = 1'b1;
    MemWrite = 1'b0;
    @(negedge clk);
    check("abort_rd", rd_m, 32'd0);
    check("abort_done", {31'd0, done_m}, 32'd0);
    check("abort_busy", {31'd0, busy_m}, 32'd0);
    reset2 = 1'b0;
    do_req(1, 0, 3'b010, 9'h020, 32'h0,        32'hCAFEF00D, 0, 1, 0);

    // back-to-back: first request held through done, next one replaces it
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hA1B255EF, 0, 1, 1);
    do_req(1, 0, 3'b010, 9'h020, 32'h0,        32'hCAFEF00D, 0, 1, 0);

    // zero wait states
    @(negedge clk);
    phase  = 1'b1;
    reset2 = 1'b1;
    @(negedge clk);
    check("reset0_rd", rd_m, 32'd0);
    check("reset0_done", {31'd0, done_m}, 32'd0);
    reset0 = 1'b0;
    do_req(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    do_req(1, 0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
